// File: rtl/add_num_job_ctrl_pkg.sv
// Shared types and defaults for the add-two-numbers batch sequencer.
//   t_job_state : sequencer states
//   DEF_*       : default operand placement / widths
//   pack_result : places an OP_W+1 bit sum into the low bits of a zeroed line
package add_num_pkg;

  localparam int unsigned DEF_DATA_W  = 512;
  localparam int unsigned DEF_OPA_LSB = 8;
  localparam int unsigned DEF_OPB_LSB = 16;
  localparam int unsigned DEF_OP_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    ADD,
    WR_REQ,
    DRAIN
  } t_job_state;

  typedef logic [DEF_OP_W:0]     t_sum;
  typedef logic [DEF_DATA_W-1:0] t_line;

  function automatic t_line pack_result(input t_sum sum);
    t_line line;
    line = '0;
    line[DEF_OP_W:0] = sum;
    return line;
  endfunction

endpackage

// File: rtl/add_num_job_ctrl_if.sv
// Host channel bundle (c0 read / c1 write) between the sequencer and CCI-P.
//   master : sequencer side (drives requests, receives responses/almfull)
//   slave  : host side
interface add_num_job_ctrl_if #(
  parameter int unsigned ADDR_W  = 42,
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned MDATA_W = 16
) ();

  logic               c0_almfull;
  logic               rd_req_valid;
  logic [ADDR_W-1:0]  rd_req_addr;
  logic [MDATA_W-1:0] rd_req_mdata;
  logic               rd_rsp_valid;
  logic [MDATA_W-1:0] rd_rsp_mdata;
  logic [DATA_W-1:0]  rd_rsp_data;

  logic               c1_almfull;
  logic               wr_req_valid;
  logic [ADDR_W-1:0]  wr_req_addr;
  logic [DATA_W-1:0]  wr_req_data;
  logic               wr_rsp_valid;

  modport master (
    input  c0_almfull,
    output rd_req_valid, rd_req_addr, rd_req_mdata,
    input  rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    input  c1_almfull,
    output wr_req_valid, wr_req_addr, wr_req_data,
    input  wr_rsp_valid
  );

  modport slave (
    output c0_almfull,
    input  rd_req_valid, rd_req_addr, rd_req_mdata,
    output rd_rsp_valid, rd_rsp_mdata, rd_rsp_data,
    output c1_almfull,
    input  wr_req_valid, wr_req_addr, wr_req_data,
    output wr_rsp_valid
  );

endinterface

// File: rtl/add_num_job_ctrl_alu.sv
// Registered operand extract + add, one cycle latency.
//   en   : capture a new sum from data this cycle
//   data : read response line
//   sum  : {1'b0,a}+{1'b0,b}, held until the next enable
module add_num_alu #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned OPA_LSB = 8,
  parameter int unsigned OPB_LSB = 16,
  parameter int unsigned OP_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [OP_W:0]     sum
);

  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic [OP_W:0]   sum_d;
  logic [OP_W:0]   sum_q;
  logic            data_unused;

  // Only the two operand fields matter; the rest of the line is dropped.
  assign data_unused = ^data;

  always_comb begin
    op_a  = data[OPA_LSB +: OP_W];
    op_b  = data[OPB_LSB +: OP_W];
    sum_d = sum_q;
    if (en) begin
      sum_d = {1'b0, op_a} + {1'b0, op_b};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/add_num_job_ctrl.sv
// Batch sequencer for the add-two-numbers datapath.
// For each line i: read src_base+i, add two operand bytes, write dst_base+i.
//   clk, reset_n               : host clock, async active-low reset
//   start/src_base/dst_base/num_lines : batch command (sampled on start in IDLE)
//   busy/done/err/lines_done   : batch status
//   host                       : c0/c1 request/response channel (master side)
module add_num_job_ctrl
  import add_num_pkg::*;
#(
  parameter int unsigned ADDR_W  = 42,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned MDATA_W = 16,
  parameter int unsigned OPA_LSB = DEF_OPA_LSB,
  parameter int unsigned OPB_LSB = DEF_OPB_LSB,
  parameter int unsigned OP_W    = DEF_OP_W
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [CNT_W-1:0]   num_lines,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   lines_done,
  add_num_job_ctrl_if.master host
);

  typedef logic [CNT_W:0] t_cnt_ext;

  t_job_state         state_d, state_q;
  logic [ADDR_W-1:0]  src_d, src_q;
  logic [ADDR_W-1:0]  dst_d, dst_q;
  logic [CNT_W-1:0]   num_d, num_q;
  logic [CNT_W-1:0]   idx_d, idx_q;
  logic [CNT_W-1:0]   lines_done_d, lines_done_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               err_d, err_q;
  logic               rd_valid_d, rd_valid_q;
  logic [ADDR_W-1:0]  rd_addr_d, rd_addr_q;
  logic [MDATA_W-1:0] rd_mdata_d, rd_mdata_q;
  logic               wr_valid_d, wr_valid_q;
  logic [ADDR_W-1:0]  wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0]  wr_data_d, wr_data_q;
  logic               alu_en;
  logic [OP_W:0]      alu_sum;
  logic               last_line;

  add_num_alu #(
    .DATA_W  (DATA_W),
    .OPA_LSB (OPA_LSB),
    .OPB_LSB (OPB_LSB),
    .OP_W    (OP_W)
  ) u_alu (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (alu_en),
    .data    (host.rd_rsp_data),
    .sum     (alu_sum)
  );

  // Widened compare so idx+1 cannot wrap when num_lines is all ones.
  assign last_line = ((t_cnt_ext'(idx_q) + t_cnt_ext'(1)) == t_cnt_ext'(num_q));

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    num_d        = num_q;
    idx_d        = idx_q;
    lines_done_d = lines_done_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    err_d        = err_q;
    rd_valid_d   = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_mdata_d   = rd_mdata_q;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    alu_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d        = src_base;
          dst_d        = dst_base;
          num_d        = num_lines;
          idx_d        = '0;
          lines_done_d = '0;
          err_d        = 1'b0;
          busy_d       = 1'b1;
          state_d      = (num_lines == '0) ? DRAIN : RD_REQ;
        end
      end
      RD_REQ: begin
        if (!host.c0_almfull) begin
          rd_valid_d = 1'b1;
          rd_addr_d  = src_q + ADDR_W'(idx_q);
          rd_mdata_d = MDATA_W'(idx_q);
          state_d    = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (host.rd_rsp_valid) begin
          if (host.rd_rsp_mdata != MDATA_W'(idx_q)) begin
            err_d = 1'b1;
          end
          alu_en  = 1'b1;
          state_d = ADD;
        end
      end
      ADD: begin
        state_d = WR_REQ;
      end
      WR_REQ: begin
        if (!host.c1_almfull) begin
          wr_valid_d = 1'b1;
          wr_addr_d  = dst_q + ADDR_W'(idx_q);
          wr_data_d  = DATA_W'(pack_result(t_sum'(alu_sum)));
          idx_d      = idx_q + CNT_W'(1);
          state_d    = last_line ? DRAIN : RD_REQ;
        end
      end
      DRAIN: begin
        if (lines_done_q == num_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Responses outside their expected windows: flag, otherwise ignore.
    // Applied after the IDLE start clear so a same-cycle stray response still sticks.
    if (host.rd_rsp_valid && (state_q != RD_WAIT)) begin
      err_d = 1'b1;
    end
    if (host.wr_rsp_valid) begin
      if (state_q == IDLE) begin
        err_d = 1'b1;
      end else begin
        lines_done_d = lines_done_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      num_q        <= '0;
      idx_q        <= '0;
      lines_done_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_addr_q    <= '0;
      rd_mdata_q   <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      num_q        <= num_d;
      idx_q        <= idx_d;
      lines_done_q <= lines_done_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      rd_valid_q   <= rd_valid_d;
      rd_addr_q    <= rd_addr_d;
      rd_mdata_q   <= rd_mdata_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign busy              = busy_q;
  assign done              = done_q;
  assign err               = err_q;
  assign lines_done        = lines_done_q;
  assign host.rd_req_valid = rd_valid_q;
  assign host.rd_req_addr  = rd_addr_q;
  assign host.rd_req_mdata = rd_mdata_q;
  assign host.wr_req_valid = wr_valid_q;
  assign host.wr_req_addr  = wr_addr_q;
  assign host.wr_req_data  = wr_data_q;

endmodule

// File: tb/tb_add_num_job_ctrl.sv
module tb_add_num_job_ctrl;

  localparam int unsigned ADDR_W  = 42;
  localparam int unsigned DATA_W  = 512;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned MDATA_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] line_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  addr_t            src_base;
  addr_t            dst_base;
  logic [CNT_W-1:0] num_lines;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] lines_done;

  always #5 clk = ~clk;

  add_num_job_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MDATA_W(MDATA_W)) host ();

  add_num_job_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W), .MDATA_W(MDATA_W),
    .OPA_LSB(8), .OPB_LSB(16), .OP_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .src_base(src_base), .dst_base(dst_base), .num_lines(num_lines),
    .busy(busy), .done(done), .err(err), .lines_done(lines_done),
    .host(host)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input line_t act, input line_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- host memory + responder model ----------------
  typedef struct {
    int                 due;
    logic [MDATA_W-1:0] tag;
    line_t              data;
  } rd_rsp_t;

  line_t              mem [addr_t];
  rd_rsp_t            rd_pend[$];
  int                 wr_pend[$];
  addr_t              rd_addr_log[$];
  logic [MDATA_W-1:0] rd_tag_log[$];
  int                 rd_cyc_log[$];
  addr_t              wr_addr_log[$];
  line_t              wr_data_log[$];
  int                 wr_cyc_log[$];
  int                 rsp_cyc_log[$];

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int wr_rsp_sent = 0;
  int wr_rsp_at_done = -1;
  int inj_cyc = -1;
  int unsigned lat_lo = 1;
  int unsigned lat_hi = 4;
  bit af_rand = 1'b0;
  bit c0_force = 1'b0;
  bit c1_force = 1'b0;
  bit corrupt_next = 1'b0;
  bit inject_rd = 1'b0;

  function automatic line_t rand_line();
    line_t l;
    for (int w = 0; w < DATA_W / 32; w++) l[w*32 +: 32] = $urandom();
    return l;
  endfunction

  function automatic line_t mem_line(input addr_t a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  // Reference: result line = byte1 + byte2 of the source line, zero-extended.
  function automatic line_t ref_result(input line_t src_line);
    int unsigned a;
    int unsigned b;
    a = src_line[8 +: 8];
    b = src_line[16 +: 8];
    return line_t'(a + b);
  endfunction

  task automatic set_ops(input addr_t a, input logic [7:0] op_a, input logic [7:0] op_b);
    line_t l;
    l = rand_line();
    l[15:8]  = op_a;
    l[23:16] = op_b;
    mem[a] = l;
  endtask

  // One cycle: observe DUT at the negedge, then drive host inputs for the next posedge.
  task automatic tick();
    rd_rsp_t r;
    @(negedge clk);
    cyc++;
    if (host.rd_req_valid === 1'b1) begin
      rd_addr_log.push_back(host.rd_req_addr);
      rd_tag_log.push_back(host.rd_req_mdata);
      rd_cyc_log.push_back(cyc);
      r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
      r.tag  = host.rd_req_mdata;
      r.data = mem_line(host.rd_req_addr);
      rd_pend.push_back(r);
    end
    if (host.wr_req_valid === 1'b1) begin
      wr_addr_log.push_back(host.wr_req_addr);
      wr_data_log.push_back(host.wr_req_data);
      wr_cyc_log.push_back(cyc);
      wr_pend.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
    end
    if (done === 1'b1) begin
      if (done_cnt == 0) done_cyc = cyc;
      done_cnt++;
      wr_rsp_at_done = wr_rsp_sent;
    end
    host.rd_rsp_valid = 1'b0;
    host.rd_rsp_mdata = '0;
    host.rd_rsp_data  = '0;
    if (rd_pend.size() > 0 && rd_pend[0].due <= cyc) begin
      r = rd_pend.pop_front();
      host.rd_rsp_valid = 1'b1;
      host.rd_rsp_mdata = corrupt_next ? (r.tag ^ MDATA_W'(5)) : r.tag;
      host.rd_rsp_data  = r.data;
      corrupt_next = 1'b0;
      rsp_cyc_log.push_back(cyc);
    end else if (inject_rd) begin
      host.rd_rsp_valid = 1'b1;
      host.rd_rsp_data  = rand_line();
      inject_rd = 1'b0;
      inj_cyc = cyc;
    end
    host.wr_rsp_valid = 1'b0;
    if (wr_pend.size() > 0 && wr_pend[0] <= cyc) begin
      void'(wr_pend.pop_front());
      host.wr_rsp_valid = 1'b1;
      wr_rsp_sent++;
    end
    host.c0_almfull = c0_force | (af_rand && ($urandom_range(3, 0) == 0));
    host.c1_almfull = c1_force | (af_rand && ($urandom_range(3, 0) == 0));
  endtask

  task automatic fill_src(input addr_t src, input int n);
    for (int i = 0; i < n; i++) set_ops(addr_t'(src + addr_t'(i)), 8'($urandom()), 8'($urandom()));
  endtask

  task automatic run_batch(input string name, input addr_t src, input addr_t dst, input int n,
                           input bit exp_err, input int c0_hold, input int c1_hold,
                           input int inj_at, input bit poke_start);
    int start_cyc;
    int c0_rel;
    int c1_rel;
    rd_addr_log.delete(); rd_tag_log.delete(); rd_cyc_log.delete();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    rsp_cyc_log.delete();
    done_cnt = 0; done_cyc = -1; wr_rsp_sent = 0; wr_rsp_at_done = -1; inj_cyc = -1;
    c0_rel = -1; c1_rel = -1;
    c0_force = (c0_hold > 0);
    c1_force = (c1_hold > 0);
    host.c0_almfull = c0_force;
    host.c1_almfull = c1_force;
    src_base = src; dst_base = dst; num_lines = CNT_W'(n);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    chk({name, " err cleared"}, err, 0);
    chk({name, " busy"}, busy, 1);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      if (c0_hold > 0 && c0_rel < 0 && cyc - start_cyc >= c0_hold) begin
        c0_force = 1'b0; host.c0_almfull = 1'b0; c0_rel = cyc;
      end
      if (c1_hold > 0 && c1_rel < 0 && cyc - start_cyc >= c1_hold) begin
        c1_force = 1'b0; host.c1_almfull = 1'b0; c1_rel = cyc;
      end
      if (inj_at > 0 && cyc - start_cyc == inj_at) inject_rd = 1'b1;
      if (poke_start && cyc - start_cyc == 4) begin
        start = 1'b1;
        src_base = addr_t'({$urandom(), $urandom()});
        dst_base = addr_t'({$urandom(), $urandom()});
        num_lines = CNT_W'($urandom());
      end else begin
        start = 1'b0;
      end
      tick();
      if (inj_cyc >= 0 && cyc == inj_cyc + 1) chk({name, " err after stray rd rsp"}, err, 1);
    end
    start = 1'b0;
    chk({name, " done seen"}, done_cnt, 1);
    chk({name, " busy at done"}, busy, 0);
    chk({name, " wr rsps before done"}, wr_rsp_at_done, n);
    repeat (4) tick();
    chk({name, " single done pulse"}, done_cnt, 1);
    chk({name, " lines_done"}, lines_done, n);
    chk({name, " err"}, err, exp_err);
    chk({name, " busy idle"}, busy, 0);
    chk({name, " rd count"}, rd_addr_log.size(), n);
    chk({name, " wr count"}, wr_addr_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < rd_addr_log.size()) begin
        chk($sformatf("%s rd addr %0d", name, i), rd_addr_log[i], addr_t'(src + addr_t'(i)));
        chk($sformatf("%s rd tag %0d", name, i), rd_tag_log[i], i);
      end
      if (i < wr_addr_log.size()) begin
        chk($sformatf("%s wr addr %0d", name, i), wr_addr_log[i], addr_t'(dst + addr_t'(i)));
        chk($sformatf("%s wr data %0d", name, i), wr_data_log[i],
            ref_result(mem_line(addr_t'(src + addr_t'(i)))));
      end
    end
    if (n > 0 && rd_cyc_log.size() > 0) begin
      if (c0_hold > 0) chk({name, " rd after c0 release"}, rd_cyc_log[0], c0_rel + 1);
      else if (!af_rand) chk({name, " start to rd latency"}, rd_cyc_log[0] - start_cyc, 2);
    end
    if (n > 0 && wr_cyc_log.size() > 0 && rsp_cyc_log.size() > 0) begin
      if (c1_hold > 0) chk({name, " wr after c1 release"}, wr_cyc_log[0], c1_rel + 1);
      else if (!af_rand) chk({name, " rsp to wr latency"}, wr_cyc_log[0] - rsp_cyc_log[0], 3);
    end
    if (n == 0) chk({name, " done within 3"}, (done_cyc >= 0) && (done_cyc - start_cyc <= 3), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    addr_t s;
    addr_t d;
    int n;
    reset_n = 1'b0; start = 1'b0;
    src_base = '0; dst_base = '0; num_lines = '0;
    host.c0_almfull = 1'b0; host.c1_almfull = 1'b0;
    host.rd_rsp_valid = 1'b0; host.rd_rsp_mdata = '0; host.rd_rsp_data = '0;
    host.wr_rsp_valid = 1'b0;
    repeat (3) tick();
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);
    chk("reset lines_done", lines_done, 0);
    chk("reset rd_req_valid", host.rd_req_valid, 0);
    chk("reset wr_req_valid", host.wr_req_valid, 0);
    reset_n = 1'b1;
    repeat (2) tick();

    set_ops(42'h100, 8'h05, 8'h07);
    run_batch("one", 42'h100, 42'h200, 1, 0, 0, 0, 0, 0);
    if (wr_data_log.size() > 0) chk("one sum 12", wr_data_log[0], 12);

    set_ops(42'h300, 8'hFF, 8'hFF);
    set_ops(42'h301, 8'h00, 8'h00);
    set_ops(42'h302, 8'h01, 8'h02);
    set_ops(42'h303, 8'h80, 8'h80);
    run_batch("four", 42'h300, 42'h400, 4, 0, 0, 0, 0, 0);
    if (wr_data_log.size() == 4) chk("four sum 0x1fe", wr_data_log[0], 'h1FE);

    run_batch("zero", 42'h500, 42'h600, 0, 0, 0, 0, 0, 0);

    fill_src(42'h700, 1);
    run_batch("c0af", 42'h700, 42'h800, 1, 0, 10, 0, 0, 0);
    fill_src(42'h900, 1);
    run_batch("c1af", 42'h900, 42'hA00, 1, 0, 0, 20, 0, 0);

    fill_src(42'hB00, 1);
    corrupt_next = 1'b1;
    run_batch("badtag", 42'hB00, 42'hC00, 1, 1, 0, 0, 0, 0);

    fill_src(42'hD00, 1);
    run_batch("stray", 42'hD00, 42'hE00, 1, 1, 0, 20, 15, 0);

    fill_src(42'hF00, 2);
    run_batch("errclr", 42'hF00, 42'h1F00, 2, 0, 0, 0, 0, 0);

    for (int b = 0; b < 8; b++) begin
      s = (b == 0) ? addr_t'('1) - addr_t'(1) : addr_t'({$urandom(), $urandom()});
      d = (b == 1) ? addr_t'('1) : addr_t'({$urandom(), $urandom()});
      n = int'($urandom_range(6, 1));
      af_rand = ($urandom_range(1, 0) == 1);
      lat_lo = 1;
      lat_hi = $urandom_range(6, 1);
      fill_src(s, n);
      run_batch($sformatf("rand%0d", b), s, d, n, 0, 0, 0, 0, 1);
    end
    af_rand = 1'b0;
    lat_lo = 1; lat_hi = 4;

    // Reset in the middle of a batch while a read is outstanding.
    rd_addr_log.delete(); rd_tag_log.delete(); rd_cyc_log.delete();
    fill_src(42'h2000, 4);
    lat_lo = 30; lat_hi = 30;
    src_base = 42'h2000; dst_base = 42'h3000; num_lines = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("midrst rd issued", rd_addr_log.size(), 1);
    chk("midrst busy before", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst err", err, 0);
    chk("midrst lines_done", lines_done, 0);
    chk("midrst rd_req_valid", host.rd_req_valid, 0);
    chk("midrst wr_req_valid", host.wr_req_valid, 0);
    rd_pend.delete(); wr_pend.delete();
    done_cnt = 0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    chk("midrst no done", done_cnt, 0);
    lat_lo = 1; lat_hi = 4;
    fill_src(42'h4000, 2);
    run_batch("post", 42'h4000, 42'h5000, 2, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_num_job_ctrl.md
Name: add_num_job_ctrl

Overview:
Sequencer for the CCI-P add-two-numbers datapath, extended from one result to a batch of jobs.
- Software programs a source base, destination base and line count, then pulses start.
- For each line i the block issues a read of src_base+i, extracts two 8-bit operands, adds them, and writes the sum to dst_base+i.
- Sits between the CSR decode and the host channel c0/c1 request/response signals inside ofs_plat_afu; replaces the single-shot hardcoded-write FSM.

Parameters:
ADDR_W, 42, cache-line address width (t_ccip_clAddr)
DATA_W, 512, cache-line data width
CNT_W, 16, width of line count and per-job counters
MDATA_W, 16, request tag width
OPA_LSB, 8, bit position of operand A in read data
OPB_LSB, 16, bit position of operand B in read data
OP_W, 8, operand width

Ports:
clk  in  1  host channel clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse from CSR write; begins a batch
src_base  in  ADDR_W  first source line address, sampled at start
dst_base  in  ADDR_W  first destination line address, sampled at start
num_lines  in  CNT_W  number of jobs, sampled at start
busy  out  1  batch in progress
done  out  1  one-cycle pulse when batch completes
err  out  1  sticky; set on a tag mismatch or an unexpected response; cleared by the next accepted start
lines_done  out  CNT_W  count of write responses received in the current batch
c0_almfull  in  1  c0TxAlmFull
rd_req_valid  out  1  read request strobe
rd_req_addr  out  ADDR_W  read line address
rd_req_mdata  out  MDATA_W  read tag = job index
rd_rsp_valid  in  1  read response valid (cci_c0Rx_isReadRsp)
rd_rsp_mdata  in  MDATA_W  read response tag
rd_rsp_data  in  DATA_W  read response data
c1_almfull  in  1  c1TxAlmFull
wr_req_valid  out  1  write request strobe (sop=1 single beat)
wr_req_addr  out  ADDR_W  write line address
wr_req_data  out  DATA_W  result line
wr_rsp_valid  in  1  write response valid

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; counters 0.
- Request strobes are registered and high for exactly one cycle per request. There is no ready signal; the almfull inputs gate issue.
- States:
  - IDLE: on start, latch the bases and count, clear err, lines_done and idx, busy=1.
    - num_lines==0 -> DRAIN.
    - Otherwise -> RD_REQ.
  - RD_REQ: if !c0_almfull, assert rd_req_valid with addr=src_base+idx and mdata=idx[MDATA_W-1:0]; go to RD_WAIT. Otherwise stay.
  - RD_WAIT: on rd_rsp_valid:
    - If mdata!=idx, set err.
    - In all cases register a=data[OPA_LSB+:OP_W] and b=data[OPB_LSB+:OP_W]; go to ADD.
  - ADD: sum={1'b0,a}+{1'b0,b} (OP_W+1 bits, no overflow loss); go to WR_REQ.
  - WR_REQ: if !c1_almfull, assert wr_req_valid with addr=dst_base+idx and data=zero-extended sum in bits [OP_W:0].
    - Then idx++.
    - If idx+1==num_lines -> DRAIN, else -> RD_REQ.
  - DRAIN: wait until lines_done==num_lines, then pulse done for one cycle, clear busy, go to IDLE.
- Write responses are counted in every non-IDLE state, including concurrently with a new read issue.
  - wr_rsp_valid in IDLE sets err and does not change lines_done.
- rd_rsp_valid in any state other than RD_WAIT sets err and is ignored.
- start while busy is ignored; latched values are not disturbed.
- Address sums wrap modulo 2^ADDR_W. The idx counter never wraps within a batch (bounded by num_lines).
- Latency:
  - start -> first rd_req_valid: 2 cycles with almfull low.
  - rd_rsp -> wr_req_valid: 3 cycles.
- Asserting reset mid-batch aborts immediately to IDLE with no done pulse. Outstanding responses arriving after reset release hit IDLE and set err; software resets the AFU before reuse.

Decomposition:
- Package add_num_pkg holds:
  - t_job_state enum (IDLE, RD_REQ, RD_WAIT, ADD, WR_REQ, DRAIN)
  - OPA_LSB/OPB_LSB/OP_W defaults
  - function pack_result(sum) returning a DATA_W line
- One sub-module, add_num_alu: registered operand extract + add, 1-cycle latency, enable input. It is instantiated once; the FSM sequences it.

Test Plan:
- num_lines=1, src line bytes[1]=0x05 and [2]=0x07 -> one read of src_base with mdata=0; write to dst_base with data=12; done pulse; lines_done=1; err=0.
- num_lines=4, operand pairs (0xFF,0xFF),(0,0),(1,2),(0x80,0x80) -> writes 0x1FE, 0, 3, 0x100 to dst_base+0..3 in order; done only after the 4th wr_rsp.
- c0_almfull held high 10 cycles after start -> no rd_req_valid during those cycles; request issued the cycle after deassert; c1_almfull the same for writes.
- num_lines=0 -> no requests; done within 3 cycles of start; busy returns to 0.
- Read response with mdata=5 while expecting 0 -> err=1 and the write still issues. Spurious rd_rsp_valid in WR_REQ -> err=1 with no state change. Next start clears err.
- Reset asserted mid-RD_WAIT of a 4-line batch -> all outputs 0 asynchronously; no done. After release, start with num_lines=2 completes normally.
